huffman_gen: RTL and testbench
==============================

# huffman_gen

Parametrised Huffman code generator for the grayscale statistics path. It accumulates a histogram of `NSYM` symbol values from a byte stream and outputs the counts. It then builds a Huffman code by repeated two-minimum merging and outputs a right-aligned code word and a length mask per symbol. It generalises the fixed six-symbol encoder to any symbol count, count width and code width, and adds count saturation, deterministic tie-breaking and back-to-back frames.

## Interface
- `NSYM`, 6: number of symbols; data values 1..`NSYM` are counted (legal range 2..15).
- `DW`, 8: input data width.
- `CW`, 8: per-symbol count width.
- `HW`, 8: code/mask width per symbol; must be ≥ `NSYM`-1.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `in_valid`  in  1  sample qualifier; a frame is one contiguous high run.
- `in_data`  in  `DW`  sample value.
- `cnt_valid`  out  1  one-cycle pulse when the counts are final.
- `cnt`  out  `NSYM*CW`  counts; symbol k+1 is at `[k*CW +: CW]`.
- `code_valid`  out  1  one-cycle pulse when the codes are final.
- `hc`  out  `NSYM*HW`  code words, right-aligned, same packing as `cnt`.
- `mask`  out  `NSYM*HW`  length masks: ones in the low len bits.
- `busy`  out  1  high from the first sample until the `code_valid` cycle, inclusive.

## Operation
- **States:** IDLE → READ → CNT_OUT → SCAN1 → SCAN2 → MERGE → (SCAN1 | DONE) → IDLE.
- **IDLE:**
  - On `in_valid`=1, clear all counts, then count that first sample. Go to READ.
- **READ:**
  - Each cycle with `in_valid`=1 and `in_data` in 1..`NSYM` increments the matching count.
  - Counts saturate at 2^`CW`-1. Out-of-range values are ignored.
  - `in_valid`=0 → CNT_OUT.
- **CNT_OUT:**
  - `cnt_valid`=1 for one cycle; `cnt` is stable from this cycle until the next frame starts.
  - Initialise the working state per symbol i:
    - group label g[i] = i (width clog2(2·`NSYM`));
    - group weight w[i] = count, width `CW`+clog2(`NSYM`);
    - code and length cleared.
- **Ordering:** groups are compared on (weight, label). Lower weight is smaller; on equal weight, the larger label is smaller. Merged groups therefore win ties.
- **SCAN1:** walks i = 0..`NSYM`-1, one symbol per cycle, and selects group A, the smallest.
- **SCAN2:** same walk, skipping members of A, and selects group B.
- **MERGE:** one cycle, merge round r = 0..`NSYM`-2.
  - Members of A get bit 1 inserted at position len[i]; members of B get bit 0.
  - len++ for members of both groups, so later rounds supply more-significant bits.
  - All members of A and B take label `NSYM`+r and weight w[A]+w[B].
  - After round `NSYM`-2, go to DONE; otherwise return to SCAN1.
- **DONE:**
  - `code_valid`=1 for one cycle.
  - `hc` and `mask` hold until the next CNT_OUT, when both are cleared.
- **Ignored input:** `in_valid` is ignored in CNT_OUT, SCAN1, SCAN2, MERGE and DONE. Samples there are lost; no error is flagged.
- **Zero counts:** zero-count symbols take part normally and receive codes.

## Timing
- **Reset values:** all outputs 0; state IDLE.
- **Async reset mid-frame:** aborts immediately. No pulses are emitted until a new frame completes.
- **`cnt_valid`:** asserted the cycle after the first `in_valid`=0 cycle.
- **`code_valid` latency:** asserted (`NSYM`-1)·(2·`NSYM`+1)+1 cycles after `cnt_valid`. This is 66 cycles for `NSYM`=6.
- **Next frame:** can start in the cycle after `code_valid` (IDLE).
- **Single-sample frame:** valid; that symbol's count is 1.

## Structure
- **Shared package:**
  - state encoding;
  - `clog2` helper;
  - label/weight width derivations;
  - the tie-break compare function, which the bench reference model reuses.
- **Sub-module `huffman_min_scan`:** one natural sub-module, instantiated once and reused by SCAN1 and SCAN2. It holds the sequential (weight, label) minimum tracker with an exclude-label input.
- **Top level:** holds the FSM, the histogram, the per-symbol arrays and the merge logic.

## Test plan
- **Skewed histogram:** frame with counts 1,1,2,4,8,16 for symbols 1..6. `cnt_valid` shows those counts.
  - `hc` = 1E,1F,0E,06,02,00 (hex).
  - `mask` = 1F,1F,0F,07,03,01.
  - `code_valid` comes exactly 66 cycles after `cnt_valid`.
- **Out-of-range data:** frame of data 0,7,255,3. Only CNT3=1; the other counts are 0; `code_valid` still pulses.
- **Saturation:** 300 consecutive samples of value 1 → CNT1=255.
- **Reset mid-SCAN2:** assert `reset` during round 2.
  - All outputs are 0 immediately and `busy`=0.
  - A following frame produces the same codes as the skewed-histogram test run alone.
- **Back-to-back and ignored input:** two frames, the second starting in the cycle after `code_valid`.
  - The second frame's counts exclude the first frame.
  - Samples driven during SCAN/MERGE are not counted.
- **Parameter sweep:** `NSYM`=8, `HW`=8, equal counts of 2.
  - Codes match the reference model.
  - Every mask is 8'h07 (all lengths 3).

Source files
------------

// File: rtl/huffman_gen_pkg.sv
// Shared definitions for the Huffman code generator: FSM state encoding,
// width helpers and the (weight, label) ordering used to pick merge groups.
package huffman_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CNT_OUT = 3'd2,
    ST_SCAN1   = 3'd3,
    ST_SCAN2   = 3'd4,
    ST_MERGE   = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Labels run 0..2*nsym-2 (leaves, then one new label per merge round).
  function automatic int unsigned label_w(input int unsigned nsym);
    return clog2(2 * nsym);
  endfunction

  // A merged weight can reach nsym * (2^cw - 1).
  function automatic int unsigned weight_w(input int unsigned nsym, input int unsigned cw);
    return cw + clog2(nsym);
  endfunction

  // Group a is smaller than group b: lower weight, or equal weight and larger label.
  function automatic logic grp_less(input logic [31:0] wa, input logic [31:0] la,
                                    input logic [31:0] wb, input logic [31:0] lb);
    return (wa < wb) || ((wa == wb) && (la > lb));
  endfunction

endpackage

// File: rtl/huffman_min_scan.sv
// Sequential minimum tracker over a symbol walk, one element per step.
// Ports: start_i marks the first element of a walk, step_i qualifies an
// element, w_i/lbl_i are its group weight/label, excl_en_i/excl_lbl_i drop
// members of an already-chosen group; min_w_o/min_lbl_o hold the running minimum.
module huffman_min_scan
  import huffman_gen_pkg::*;
#(
  parameter int unsigned WW = 11,
  parameter int unsigned LW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  input  logic          step_i,
  input  logic [WW-1:0] w_i,
  input  logic [LW-1:0] lbl_i,
  input  logic          excl_en_i,
  input  logic [LW-1:0] excl_lbl_i,
  output logic [WW-1:0] min_w_o,
  output logic [LW-1:0] min_lbl_o
);

  logic          have_q, have_d;
  logic [WW-1:0] min_w_q, min_w_d;
  logic [LW-1:0] min_lbl_q, min_lbl_d;
  logic          cand_ok, take;

  // A new walk discards the previous result; excluded members never qualify.
  always_comb begin
    have_d    = have_q;
    min_w_d   = min_w_q;
    min_lbl_d = min_lbl_q;
    cand_ok   = !(excl_en_i && (lbl_i == excl_lbl_i));
    take      = step_i && cand_ok &&
                (start_i || !have_q ||
                 grp_less(32'(w_i), 32'(lbl_i), 32'(min_w_q), 32'(min_lbl_q)));
    if (step_i && start_i) have_d = 1'b0;
    if (take) begin
      have_d    = 1'b1;
      min_w_d   = w_i;
      min_lbl_d = lbl_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      have_q    <= 1'b0;
      min_w_q   <= '0;
      min_lbl_q <= '0;
    end else begin
      have_q    <= have_d;
      min_w_q   <= min_w_d;
      min_lbl_q <= min_lbl_d;
    end
  end

  assign min_w_o   = min_w_q;
  assign min_lbl_o = min_lbl_q;

endmodule

// File: rtl/huffman_gen.sv
// Histogram accumulator and Huffman code builder by repeated two-minimum merging.
// Ports: in_valid/in_data carry one frame as a contiguous valid run;
// cnt_valid pulses with final counts on cnt; code_valid pulses with final
// right-aligned codes on hc and length masks on mask; busy spans a frame.
module huffman_gen
  import huffman_gen_pkg::*;
#(
  parameter int unsigned NSYM = 6,
  parameter int unsigned DW   = 8,
  parameter int unsigned CW   = 8,
  parameter int unsigned HW   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [DW-1:0]        in_data,
  output logic                 cnt_valid,
  output logic [NSYM*CW-1:0]   cnt,
  output logic                 code_valid,
  output logic [NSYM*HW-1:0]   hc,
  output logic [NSYM*HW-1:0]   mask,
  output logic                 busy
);

  localparam int unsigned LW = label_w(NSYM);
  localparam int unsigned WW = weight_w(NSYM, CW);
  localparam int unsigned IW = clog2(NSYM);
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] round_q, round_d;
  logic [WW-1:0] a_w_q, a_w_d;
  logic [LW-1:0] a_lbl_q, a_lbl_d;
  logic          cnt_valid_q, cnt_valid_d;
  logic          code_valid_q, code_valid_d;
  logic          busy_q, busy_d;

  logic [CW-1:0] cnt_q  [NSYM];
  logic [CW-1:0] cnt_d  [NSYM];
  logic [LW-1:0] g_q    [NSYM];
  logic [LW-1:0] g_d    [NSYM];
  logic [WW-1:0] w_q    [NSYM];
  logic [WW-1:0] w_d    [NSYM];
  logic [HW-1:0] code_q [NSYM];
  logic [HW-1:0] code_d [NSYM];
  logic [HW-1:0] mask_q [NSYM];
  logic [HW-1:0] mask_d [NSYM];

  logic          in_range;
  logic [IW-1:0] sym;
  logic          scan_step, scan_excl_en;
  logic [LW-1:0] scan_excl_lbl, scan_lbl, merge_lbl;
  logic [WW-1:0] scan_w, merge_w;

  assign in_range = (in_data != '0) && (32'(in_data) <= NSYM);
  assign sym      = IW'(32'(in_data) - 32'd1);

  // Scanner result is group A on the first SCAN2 cycle and B during MERGE.
  // A is latched on that first SCAN2 cycle, so exclusion reads the live result then.
  assign scan_step     = (state_q == ST_SCAN1) || (state_q == ST_SCAN2);
  assign scan_excl_en  = (state_q == ST_SCAN2);
  assign scan_excl_lbl = (idx_q == '0) ? scan_lbl : a_lbl_q;

  huffman_min_scan #(
    .WW(WW),
    .LW(LW)
  ) u_scan (
    .clk        (clk),
    .reset      (reset),
    .start_i    (idx_q == '0),
    .step_i     (scan_step),
    .w_i        (w_q[idx_q]),
    .lbl_i      (g_q[idx_q]),
    .excl_en_i  (scan_excl_en),
    .excl_lbl_i (scan_excl_lbl),
    .min_w_o    (scan_w),
    .min_lbl_o  (scan_lbl)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state, histogram and merge datapath.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    round_d      = round_q;
    a_w_d        = a_w_q;
    a_lbl_d      = a_lbl_q;
    cnt_valid_d  = 1'b0;
    code_valid_d = 1'b0;
    cnt_d        = cnt_q;
    g_d          = g_q;
    w_d          = w_q;
    code_d       = code_q;
    mask_d       = mask_q;
    merge_lbl    = LW'(NSYM) + LW'(round_q);
    merge_w      = a_w_q + scan_w;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_READ;
          for (int unsigned k = 0; k < NSYM; k++)
            cnt_d[k] = (in_range && (sym == IW'(k))) ? CW'(1) : '0;
        end
      end
      ST_READ: begin
        if (in_valid) begin
          for (int unsigned k = 0; k < NSYM; k++)
            if (in_range && (sym == IW'(k)) && (cnt_q[k] != CNT_MAX))
              cnt_d[k] = cnt_q[k] + CW'(1);
        end else begin
          state_d     = ST_CNT_OUT;
          cnt_valid_d = 1'b1;
          idx_d       = '0;
          round_d     = '0;
          for (int unsigned k = 0; k < NSYM; k++) begin
            g_d[k]    = LW'(k);
            w_d[k]    = WW'(cnt_q[k]);
            code_d[k] = '0;
            mask_d[k] = '0;
          end
        end
      end
      ST_CNT_OUT: begin
        state_d = ST_SCAN1;
        idx_d   = '0;
      end
      ST_SCAN1: begin
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(NSYM - 1)) begin
          idx_d   = '0;
          state_d = ST_SCAN2;
        end
      end
      ST_SCAN2: begin
        if (idx_q == '0) begin
          a_w_d   = scan_w;
          a_lbl_d = scan_lbl;
        end
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(NSYM - 1)) begin
          idx_d   = '0;
          state_d = ST_MERGE;
        end
      end
      ST_MERGE: begin
        // New bit lands just above the current length: the lowest zero of the mask.
        for (int unsigned k = 0; k < NSYM; k++) begin
          if (g_q[k] == a_lbl_q) begin
            code_d[k] = code_q[k] | (~mask_q[k] & ((mask_q[k] << 1) | HW'(1)));
            mask_d[k] = (mask_q[k] << 1) | HW'(1);
            g_d[k]    = merge_lbl;
            w_d[k]    = merge_w;
          end else if (g_q[k] == scan_lbl) begin
            mask_d[k] = (mask_q[k] << 1) | HW'(1);
            g_d[k]    = merge_lbl;
            w_d[k]    = merge_w;
          end
        end
        if (round_q == IW'(NSYM - 2)) begin
          state_d      = ST_DONE;
          code_valid_d = 1'b1;
        end else begin
          round_d = round_q + IW'(1);
          state_d = ST_SCAN1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q        <= '0;
      round_q      <= '0;
      a_w_q        <= '0;
      a_lbl_q      <= '0;
      cnt_valid_q  <= 1'b0;
      code_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      for (int unsigned k = 0; k < NSYM; k++) begin
        cnt_q[k]  <= '0;
        g_q[k]    <= '0;
        w_q[k]    <= '0;
        code_q[k] <= '0;
        mask_q[k] <= '0;
      end
    end else begin
      idx_q        <= idx_d;
      round_q      <= round_d;
      a_w_q        <= a_w_d;
      a_lbl_q      <= a_lbl_d;
      cnt_valid_q  <= cnt_valid_d;
      code_valid_q <= code_valid_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
      g_q          <= g_d;
      w_q          <= w_d;
      code_q       <= code_d;
      mask_q       <= mask_d;
    end
  end

  // Pack the per-symbol registers onto the output buses.
  always_comb begin
    cnt  = '0;
    hc   = '0;
    mask = '0;
    for (int unsigned k = 0; k < NSYM; k++) begin
      cnt[k*CW +: CW]  = cnt_q[k];
      hc[k*HW +: HW]   = code_q[k];
      mask[k*HW +: HW] = mask_q[k];
    end
  end

  assign cnt_valid  = cnt_valid_q;
  assign code_valid = code_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_huffman_gen.sv
// Self-checking bench for huffman_gen: default 6-symbol instance plus an
// 8-symbol instance; expected frames are queued at stimulus time and
// compared when the DUT pulses cnt_valid / code_valid.
module tb_huffman_gen;
  import huffman_gen_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_valid8;
  logic [7:0]  in_data, in_data8;
  logic        cnt_valid, code_valid, busy;
  logic [47:0] cnt, hc, mask;
  logic        cnt_valid8, code_valid8, busy8;
  logic [63:0] cnt8, hc8, mask8;

  typedef struct {
    logic [63:0] cnt;
    logic [63:0] hc;
    logic [63:0] mask;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned stim[$];
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  huffman_gen u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .cnt_valid(cnt_valid), .cnt(cnt), .code_valid(code_valid),
    .hc(hc), .mask(mask), .busy(busy)
  );

  huffman_gen #(.NSYM(8), .DW(8), .CW(8), .HW(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_data(in_data8),
    .cnt_valid(cnt_valid8), .cnt(cnt8), .code_valid(code_valid8),
    .hc(hc8), .mask(mask8), .busy(busy8)
  );

  // Histogram of the current stimulus, saturating at 255, symbols 1..n.
  function automatic logic [63:0] hist(input int unsigned n);
    int unsigned c[16];
    logic [63:0] r;
    foreach (c[k]) c[k] = 0;
    foreach (stim[i])
      if (stim[i] >= 1 && stim[i] <= n && c[stim[i]-1] < 255) c[stim[i]-1]++;
    r = '0;
    for (int unsigned k = 0; k < n; k++) r[k*8 +: 8] = 8'(c[k]);
    return r;
  endfunction

  // Reference Huffman build on plain arrays.
  task automatic ref_codes(input int unsigned n, input logic [63:0] cnts,
                           output logic [63:0] hcv, output logic [63:0] mv);
    int unsigned g[16], w[16], code[16], len[16];
    int unsigned al, aw, bl, bw;
    bit have;
    al = 0; aw = 0; bl = 0; bw = 0;
    for (int unsigned i = 0; i < n; i++) begin
      g[i] = i; w[i] = 32'(cnts[i*8 +: 8]); code[i] = 0; len[i] = 0;
    end
    for (int unsigned r = 0; r + 1 < n; r++) begin
      have = 0;
      for (int unsigned i = 0; i < n; i++)
        if (!have || grp_less(w[i], g[i], aw, al)) begin have = 1; aw = w[i]; al = g[i]; end
      have = 0;
      for (int unsigned i = 0; i < n; i++)
        if (g[i] != al && (!have || grp_less(w[i], g[i], bw, bl))) begin
          have = 1; bw = w[i]; bl = g[i];
        end
      for (int unsigned i = 0; i < n; i++) begin
        if (g[i] == al) begin
          code[i] = code[i] | (32'd1 << len[i]); len[i]++; g[i] = n + r; w[i] = aw + bw;
        end else if (g[i] == bl) begin
          len[i]++; g[i] = n + r; w[i] = aw + bw;
        end
      end
    end
    hcv = '0; mv = '0;
    for (int unsigned i = 0; i < n; i++) begin
      hcv[i*8 +: 8] = 8'(code[i]);
      mv[i*8 +: 8]  = 8'((32'd1 << len[i]) - 1);
    end
  endtask

  task automatic send_frame(input bit sel8);
    foreach (stim[i]) begin
      if (sel8) begin in_valid8 = 1'b1; in_data8 = 8'(stim[i]); end
      else      begin in_valid  = 1'b1; in_data  = 8'(stim[i]); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_data = '0; in_valid8 = 1'b0; in_data8 = '0;
  endtask

  task automatic wait_cnt(input bit sel8, output bit ok);
    int n;
    ok = 0; n = 0;
    while (!ok && n < 20) begin
      @(posedge clk); #1; n++;
      ok = sel8 ? (cnt_valid8 === 1'b1) : (cnt_valid === 1'b1);
    end
  endtask

  // Counts edges from the cnt_valid cycle to code_valid; optionally drives
  // samples on the 6-symbol input for lat in [jfrom, jto).
  task automatic wait_code(input bit sel8, input int jfrom, input int jto,
                           output bit ok, output int lat);
    ok = 0; lat = 0;
    while (!ok && lat < 300) begin
      if (lat >= jfrom && lat < jto) begin in_valid = 1'b1; in_data = 8'd4; end
      else begin in_valid = 1'b0; in_data = '0; end
      @(posedge clk); #1; lat++;
      ok = sel8 ? (code_valid8 === 1'b1) : (code_valid === 1'b1);
    end
    in_valid = 1'b0; in_data = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cnt_valid !== 1'b0 || code_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_flags got=%b%b%b exp=000", cnt_valid, code_valid, busy);
    end
    checks++;
    if (cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", cnt); end
    checks++;
    if (hc !== '0 || mask !== '0) begin
      failures++; $display("FAIL reset_codes got hc=%h mask=%h exp=0", hc, mask);
    end
    checks++;
    if (cnt_valid8 !== 1'b0 || code_valid8 !== 1'b0 || busy8 !== 1'b0 || cnt8 !== '0 ||
        hc8 !== '0 || mask8 !== '0) begin
      failures++; $display("FAIL reset_dut8 got cnt=%h hc=%h mask=%h exp=0", cnt8, hc8, mask8);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_skewed();
    exp_t e, x;
    bit ok;
    int lat;
    stim.delete();
    stim.push_back(1); stim.push_back(2); stim.push_back(3); stim.push_back(3);
    repeat (4)  stim.push_back(4);
    repeat (8)  stim.push_back(5);
    repeat (16) stim.push_back(6);
    e.cnt  = 64'h0000_1008_0402_0101;
    e.hc   = 64'h0000_0002_060E_1F1E;
    e.mask = 64'h0000_0103_070F_1F1F;
    exp_q.push_back(e);
    send_frame(1'b0);
    wait_cnt(1'b0, ok);
    checks++;
    if (!ok || exp_q.size() == 0 || 64'(cnt) !== exp_q[0].cnt) begin
      failures++; $display("FAIL skewed_cnt got=%h exp=%h seen=%0d", cnt, e.cnt, ok);
    end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL skewed_busy got=%b exp=1", busy); end
    wait_code(1'b0, 0, 0, ok, lat);
    x = e;
    if (exp_q.size() != 0) x = exp_q.pop_front();
    checks++;
    if (!ok || lat != 66) begin failures++; $display("FAIL skewed_latency got=%0d exp=66", lat); end
    checks++;
    if (64'(hc) !== x.hc) begin failures++; $display("FAIL skewed_hc got=%h exp=%h", hc, x.hc); end
    checks++;
    if (64'(mask) !== x.mask) begin
      failures++; $display("FAIL skewed_mask got=%h exp=%h", mask, x.mask);
    end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL skewed_busy_done got=%b exp=1", busy); end
    @(posedge clk); #1;
    checks++;
    if (code_valid !== 1'b0 || busy !== 1'b0 || 64'(hc) !== x.hc) begin
      failures++; $display("FAIL skewed_after got cv=%b busy=%b hc=%h exp cv=0 busy=0 hc=%h",
                           code_valid, busy, hc, x.hc);
    end
  endtask

  task automatic test_out_of_range();
    exp_t e, x;
    bit ok;
    int lat;
    stim.delete();
    stim.push_back(0); stim.push_back(7); stim.push_back(255); stim.push_back(3);
    e.cnt = 64'h0000_0000_0001_0000;
    ref_codes(6, e.cnt, e.hc, e.mask);
    exp_q.push_back(e);
    send_frame(1'b0);
    wait_cnt(1'b0, ok);
    checks++;
    if (!ok || exp_q.size() == 0 || 64'(cnt) !== exp_q[0].cnt) begin
      failures++; $display("FAIL oor_cnt got=%h exp=%h", cnt, e.cnt);
    end
    wait_code(1'b0, 0, 0, ok, lat);
    x = e;
    if (exp_q.size() != 0) x = exp_q.pop_front();
    checks++;
    if (!ok || lat != 66) begin failures++; $display("FAIL oor_code_valid got=%0d exp=66", lat); end
    checks++;
    if (64'(hc) !== x.hc || 64'(mask) !== x.mask) begin
      failures++; $display("FAIL oor_codes got hc=%h mask=%h exp hc=%h mask=%h", hc, mask, x.hc, x.mask);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    exp_t e, x;
    bit ok;
    int lat;
    stim.delete();
    repeat (300) stim.push_back(1);
    e.cnt = hist(6);
    ref_codes(6, e.cnt, e.hc, e.mask);
    exp_q.push_back(e);
    send_frame(1'b0);
    wait_cnt(1'b0, ok);
    checks++;
    if (!ok || exp_q.size() == 0 || 64'(cnt) !== 64'h0000_0000_0000_00FF) begin
      failures++; $display("FAIL sat_cnt got=%h exp=%h", cnt, 64'h00FF);
    end
    wait_code(1'b0, 0, 0, ok, lat);
    x = e;
    if (exp_q.size() != 0) x = exp_q.pop_front();
    checks++;
    if (!ok || 64'(hc) !== x.hc || 64'(mask) !== x.mask) begin
      failures++; $display("FAIL sat_codes got hc=%h mask=%h exp hc=%h mask=%h", hc, mask, x.hc, x.mask);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit ok, pulsed;
    stim.delete();
    stim.push_back(6); stim.push_back(5); stim.push_back(4);
    e.cnt = hist(6);
    ref_codes(6, e.cnt, e.hc, e.mask);
    exp_q.push_back(e);
    send_frame(1'b0);
    wait_cnt(1'b0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rstmid_cnt_valid got=0 exp=1"); end
    repeat (35) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
    #2 reset = 1'b1;
    #1;
    exp_q.delete();
    checks++;
    if (cnt_valid !== 1'b0 || code_valid !== 1'b0 || busy !== 1'b0 || cnt !== '0 ||
        hc !== '0 || mask !== '0) begin
      failures++; $display("FAIL rstmid_outputs got cnt=%h hc=%h mask=%h busy=%b exp all 0",
                           cnt, hc, mask, busy);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    pulsed = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (cnt_valid !== 1'b0 || code_valid !== 1'b0) pulsed = 1;
    end
    checks++;
    if (pulsed) begin failures++; $display("FAIL rstmid_no_pulse got=1 exp=0"); end
    test_skewed();
  endtask

  task automatic test_back_to_back();
    exp_t ea, eb, x;
    bit ok;
    int lat;
    stim.delete();
    repeat (5) stim.push_back(1);
    repeat (3) stim.push_back(2);
    repeat (2) stim.push_back(6);
    ea.cnt = hist(6);
    ref_codes(6, ea.cnt, ea.hc, ea.mask);
    exp_q.push_back(ea);
    send_frame(1'b0);
    wait_cnt(1'b0, ok);
    checks++;
    if (!ok || exp_q.size() == 0 || 64'(cnt) !== exp_q[0].cnt) begin
      failures++; $display("FAIL b2b_a_cnt got=%h exp=%h", cnt, ea.cnt);
    end
    wait_code(1'b0, 3, 40, ok, lat);
    x = ea;
    if (exp_q.size() != 0) x = exp_q.pop_front();
    checks++;
    if (!ok || lat != 66 || 64'(hc) !== x.hc || 64'(mask) !== x.mask) begin
      failures++; $display("FAIL b2b_a_codes got lat=%0d hc=%h mask=%h exp lat=66 hc=%h mask=%h",
                           lat, hc, mask, x.hc, x.mask);
    end
    @(posedge clk); #1;
    stim.delete();
    stim.push_back(4); stim.push_back(4); stim.push_back(5); stim.push_back(3);
    eb.cnt = hist(6);
    ref_codes(6, eb.cnt, eb.hc, eb.mask);
    exp_q.push_back(eb);
    send_frame(1'b0);
    wait_cnt(1'b0, ok);
    checks++;
    if (!ok || exp_q.size() == 0 || 64'(cnt) !== exp_q[0].cnt) begin
      failures++; $display("FAIL b2b_b_cnt got=%h exp=%h", cnt, eb.cnt);
    end
    wait_code(1'b0, 0, 0, ok, lat);
    x = eb;
    if (exp_q.size() != 0) x = exp_q.pop_front();
    checks++;
    if (!ok || 64'(hc) !== x.hc || 64'(mask) !== x.mask) begin
      failures++; $display("FAIL b2b_b_codes got hc=%h mask=%h exp hc=%h mask=%h", hc, mask, x.hc, x.mask);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sweep8();
    exp_t e, x;
    bit ok;
    int lat;
    stim.delete();
    for (int unsigned s = 1; s <= 8; s++) begin stim.push_back(s); stim.push_back(s); end
    e.cnt = hist(8);
    ref_codes(8, e.cnt, e.hc, e.mask);
    exp_q.push_back(e);
    send_frame(1'b1);
    wait_cnt(1'b1, ok);
    checks++;
    if (!ok || exp_q.size() == 0 || cnt8 !== exp_q[0].cnt) begin
      failures++; $display("FAIL sweep_cnt got=%h exp=%h", cnt8, e.cnt);
    end
    wait_code(1'b1, 0, 0, ok, lat);
    x = e;
    if (exp_q.size() != 0) x = exp_q.pop_front();
    checks++;
    if (!ok || lat != 120) begin failures++; $display("FAIL sweep_latency got=%0d exp=120", lat); end
    checks++;
    if (hc8 !== x.hc) begin failures++; $display("FAIL sweep_hc got=%h exp=%h", hc8, x.hc); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (mask8[k*8 +: 8] !== 8'h07) begin
        failures++; $display("FAIL sweep_mask%0d got=%h exp=07", k + 1, mask8[k*8 +: 8]);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_data = '0;
    in_valid8 = 1'b0; in_data8 = '0;
    test_reset();
    test_skewed();
    test_out_of_range();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    test_sweep8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
